// File: rtl/csm_requester_if.sv
// rtl/csm_requester_if.sv - command/response and CSM port signals for csm_requester
interface csm_requester_if #(
    parameter int DATABITS = 8,
    parameter int MEMSIZE  = 8
);
    localparam int MEMBITS = $clog2(MEMSIZE);

    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_op;
    logic [MEMBITS-1:0]  cmd_addr;
    logic [DATABITS-1:0] cmd_wdata;
    logic                rsp_valid;
    logic [DATABITS-1:0] rsp_rdata;
    logic [1:0]          rsp_err;
    logic [DATABITS-1:0] csm_in_AD;
    logic                csm_rw;
    logic                csm_enable;
    logic                csm_hold;
    logic                csm_release;
    logic [DATABITS-1:0] csm_out_data;
    logic [1:0]          csm_err;
    logic                csm_ack;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, csm_out_data, csm_err, csm_ack,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
               csm_in_AD, csm_rw, csm_enable, csm_hold, csm_release
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, csm_out_data, csm_err, csm_ack,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
               csm_in_AD, csm_rw, csm_enable, csm_hold, csm_release
    );
endinterface

// File: rtl/csm_requester.sv
// rtl/csm_requester.sv - processor-side initiator sequencing commands onto one CSM port
module csm_requester #(
    parameter int DATABITS  = 8,
    parameter int MEMSIZE   = 8,
    parameter int MAX_RETRY = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    csm_requester_if.master bus
);
    localparam int MEMBITS = $clog2(MEMSIZE);
    localparam int RBITS   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [1:0] OP_READ    = 2'b00;
    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [1:0] OP_LOCK    = 2'b10;
    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_IN_USE = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_RETRY, S_HOLD_REQ, S_REL, S_RESP
    } state_t;

    state_t              r_state, w_next;
    logic [1:0]          r_op, w_op;
    logic [MEMBITS-1:0]  r_addr, w_addr;
    logic [DATABITS-1:0] r_wdata, w_wdata;
    logic                r_locked, w_locked_next;
    logic [RBITS-1:0]    r_retry, w_retry_next;
    logic                w_accept, w_retry_left;
    logic [DATABITS-1:0] r_ad, w_ad;
    logic                r_rw, w_rw, r_en, w_en, r_hold, w_hold, r_rel, w_rel;
    logic                r_rsp_valid;
    logic [DATABITS-1:0] r_rsp_rdata, w_rsp_rdata;
    logic [1:0]          r_rsp_err, w_rsp_err;

    assign w_accept     = bus.cmd_valid && (r_state == S_IDLE);
    assign w_retry_left = (r_retry < RBITS'(MAX_RETRY));
    // Bus outputs are computed from the next state, so the accepted command must be visible before it is latched.
    assign w_op    = w_accept ? bus.cmd_op    : r_op;
    assign w_addr  = w_accept ? bus.cmd_addr  : r_addr;
    assign w_wdata = w_accept ? bus.cmd_wdata : r_wdata;

    always_comb begin
        w_next        = r_state;
        w_locked_next = r_locked;
        w_retry_next  = r_retry;
        w_rsp_rdata   = '0;
        w_rsp_err     = ERR_NONE;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_retry_next = '0;
                    case (bus.cmd_op)
                        OP_READ, OP_WRITE: w_next = S_ADDR;
                        OP_LOCK:           w_next = r_locked ? S_RESP : S_HOLD_REQ;
                        default: begin
                            w_next = r_locked ? S_REL : S_RESP;
                            if (!r_locked) w_rsp_err = ERR_IN_USE;
                        end
                    endcase
                end
            end
            S_ADDR, S_HOLD_REQ: begin
                if (bus.csm_ack) begin
                    if (r_state == S_ADDR) begin
                        w_next = S_DATA;
                    end else begin
                        w_next        = S_RESP;
                        w_locked_next = 1'b1;
                    end
                end else if (w_retry_left) begin
                    w_next = S_RETRY;
                end else begin
                    w_next    = S_RESP;
                    w_rsp_err = bus.csm_err;
                end
            end
            S_DATA: begin
                w_next = S_RESP;
                if (r_op == OP_READ) w_rsp_rdata = bus.csm_out_data;
            end
            S_RETRY: begin
                w_retry_next = r_retry + 1'b1;
                w_next       = (r_op == OP_LOCK) ? S_HOLD_REQ : S_ADDR;
            end
            S_REL: begin
                w_next        = S_RESP;
                w_locked_next = 1'b0;
            end
            S_RESP: begin
                w_next       = S_IDLE;
                w_retry_next = '0;
            end
            default: w_next = S_IDLE;
        endcase

        w_ad   = '0;
        w_rw   = 1'b0;
        w_en   = 1'b0;
        w_rel  = 1'b0;
        w_hold = w_locked_next;
        case (w_next)
            S_ADDR: begin
                w_en = 1'b1;
                w_rw = (w_op == OP_WRITE);
                w_ad = DATABITS'(w_addr);
            end
            S_DATA:     w_ad = (w_op == OP_WRITE) ? w_wdata : '0;
            S_HOLD_REQ: w_hold = 1'b1;
            S_REL: begin
                w_hold = 1'b0;
                w_rel  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_locked    <= 1'b0;
            r_retry     <= '0;
            r_ad        <= '0;
            r_rw        <= 1'b0;
            r_en        <= 1'b0;
            r_hold      <= 1'b0;
            r_rel       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= '0;
        end else begin
            r_state  <= w_next;
            r_locked <= w_locked_next;
            r_retry  <= w_retry_next;
            if (w_accept) begin
                r_op    <= bus.cmd_op;
                r_addr  <= bus.cmd_addr;
                r_wdata <= bus.cmd_wdata;
            end
            r_ad        <= w_ad;
            r_rw        <= w_rw;
            r_en        <= w_en;
            r_hold      <= w_hold;
            r_rel       <= w_rel;
            r_rsp_valid <= (w_next == S_RESP);
            r_rsp_rdata <= w_rsp_rdata;
            r_rsp_err   <= w_rsp_err;
        end
    end

    assign bus.cmd_ready   = (r_state == S_IDLE);
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.csm_in_AD   = r_ad;
    assign bus.csm_rw      = r_rw;
    assign bus.csm_enable  = r_en;
    assign bus.csm_hold    = r_hold;
    assign bus.csm_release = r_rel;
endmodule

// File: tb/tb_csm_requester.sv
// tb/tb_csm_requester.sv - cycle-trace model bench for csm_requester
module tb_csm_requester;
    localparam int DATABITS  = 8;
    localparam int MEMSIZE   = 8;
    localparam int MAX_RETRY = 3;
    localparam logic [1:0] RD = 2'b00, WR = 2'b01, LK = 2'b10, UL = 2'b11;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    csm_requester_if #(.DATABITS(DATABITS), .MEMSIZE(MEMSIZE)) bus ();

    csm_requester #(.DATABITS(DATABITS), .MEMSIZE(MEMSIZE), .MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    typedef struct packed {
        logic       rdy;
        logic       rv;
        logic [7:0] rd;
        logic [1:0] re;
        logic [7:0] ad;
        logic       rw;
        logic       en;
        logic       hold;
        logic       rel;
    } obs_t;

    typedef struct {
        obs_t       exp;
        logic       accept;
        logic       ack;
        logic [1:0] err;
        logic [7:0] odata;
    } cyc_t;

    cyc_t       tr[$];
    logic [7:0] mem [0:MEMSIZE-1];
    bit         model_locked;
    int         n_checks = 0;
    int         n_fail = 0;
    int         lat_obs;
    logic [7:0] rd_obs;
    logic [1:0] re_obs;

    function automatic obs_t sample();
        obs_t o;
        o.rdy = bus.cmd_ready;   o.rv = bus.rsp_valid;  o.rd = bus.rsp_rdata; o.re = bus.rsp_err;
        o.ad  = bus.csm_in_AD;   o.rw = bus.csm_rw;     o.en = bus.csm_enable;
        o.hold = bus.csm_hold;   o.rel = bus.csm_release;
        return o;
    endfunction

    function automatic cyc_t mk(input logic en, input logic rw, input logic [7:0] ad,
                                input logic hold, input logic rel);
        cyc_t c;
        c.exp = '0;
        c.exp.en = en; c.exp.rw = rw; c.exp.ad = ad; c.exp.hold = hold; c.exp.rel = rel;
        c.accept = 1'b0; c.ack = 1'b0; c.err = 2'b00; c.odata = 8'hEE;
        return c;
    endfunction

    function automatic obs_t idle_obs();
        obs_t o;
        o = '0;
        o.rdy = 1'b1;
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_resp(input logic [7:0] rd, input logic [1:0] re, input logic hold);
        cyc_t c;
        c = mk(1'b0, 1'b0, 8'h00, hold, 1'b0);
        c.exp.rv = 1'b1; c.exp.rd = rd; c.exp.re = re;
        tr.push_back(c);
    endtask

    // Expected per-cycle bus picture of one command, derived from attempt counts and the lock flag.
    task automatic build(input logic [1:0] op, input int addr, input logic [7:0] wdata,
                         input int fails, input logic [1:0] errc);
        cyc_t c;
        logic [7:0] a8;
        a8 = 8'(addr);
        c = mk(1'b0, 1'b0, 8'h00, model_locked, 1'b0);
        c.exp.rdy = 1'b1; c.accept = 1'b1;
        tr.push_back(c);
        if (op == RD || op == WR) begin
            for (int a = 0; a <= MAX_RETRY; a++) begin
                c = mk(1'b1, op == WR, a8, model_locked, 1'b0);
                c.ack = (a >= fails); c.err = errc;
                tr.push_back(c);
                if (a >= fails) begin
                    c = mk(1'b0, 1'b0, (op == WR) ? wdata : 8'h00, model_locked, 1'b0);
                    if (op == RD) c.odata = mem[addr];
                    tr.push_back(c);
                    push_resp((op == RD) ? mem[addr] : 8'h00, 2'b00, model_locked);
                    if (op == WR) mem[addr] = wdata;
                    break;
                end
                if (a < MAX_RETRY) tr.push_back(mk(1'b0, 1'b0, 8'h00, model_locked, 1'b0));
                else push_resp(8'h00, errc, model_locked);
            end
        end else if (op == LK) begin
            if (model_locked) begin
                push_resp(8'h00, 2'b00, 1'b1);
            end else begin
                for (int a = 0; a <= MAX_RETRY; a++) begin
                    c = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
                    c.ack = (a >= fails); c.err = errc;
                    tr.push_back(c);
                    if (a >= fails) begin
                        model_locked = 1'b1;
                        push_resp(8'h00, 2'b00, 1'b1);
                        break;
                    end
                    if (a < MAX_RETRY) tr.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0));
                    else push_resp(8'h00, errc, 1'b0);
                end
            end
        end else begin
            if (!model_locked) begin
                push_resp(8'h00, 2'b01, 1'b0);
            end else begin
                c = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
                c.err = 2'b11;
                tr.push_back(c);
                model_locked = 1'b0;
                push_resp(8'h00, 2'b00, 1'b0);
            end
        end
    endtask

    task automatic step(input int n, input logic [1:0] op, input int addr, input logic [7:0] wdata);
        cyc_t c;
        obs_t act;
        for (int i = 0; i < n && tr.size() > 0; i++) begin
            @(negedge clk);
            c = tr.pop_front();
            bus.cmd_valid    = c.accept;
            bus.cmd_op       = op;
            bus.cmd_addr     = addr[2:0];
            bus.cmd_wdata    = wdata;
            bus.csm_ack      = c.ack;
            bus.csm_err      = c.err;
            bus.csm_out_data = c.odata;
            act = sample();
            check($sformatf("cycle %0d outputs", i), 32'(act), 32'(c.exp));
            if (act.rv && lat_obs < 0) begin
                lat_obs = i; rd_obs = act.rd; re_obs = act.re;
            end
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.csm_ack   = 1'b0;
        tr.delete();
    endtask

    task automatic run_cmd(input string name, input logic [1:0] op, input int addr,
                           input logic [7:0] wdata, input int fails, input logic [1:0] errc,
                           input int exp_lat, input logic [7:0] exp_rd, input logic [1:0] exp_re);
        build(op, addr, wdata, fails, errc);
        lat_obs = -1; rd_obs = 8'h00; re_obs = 2'b00;
        step(tr.size(), op, addr, wdata);
        check({name, " latency"}, 32'(lat_obs), 32'(exp_lat));
        check({name, " rsp_rdata"}, 32'(rd_obs), 32'(exp_rd));
        check({name, " rsp_err"}, 32'(re_obs), 32'(exp_re));
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_addr = '0; bus.cmd_wdata = '0;
        bus.csm_ack = 1'b0; bus.csm_err = 2'b00; bus.csm_out_data = '0;
        for (int i = 0; i < MEMSIZE; i++) mem[i] = 8'h00;
        model_locked = 1'b0;

        #1 check("in reset outputs", 32'(sample()), 32'(idle_obs()));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("after reset outputs", 32'(sample()), 32'(idle_obs()));

        run_cmd("write 3",          WR, 3, 8'hA5, 0,  2'b00, 3, 8'h00, 2'b00);
        run_cmd("read 3",           RD, 3, 8'h00, 0,  2'b00, 3, 8'hA5, 2'b00);
        run_cmd("write 5",          WR, 5, 8'h3C, 0,  2'b00, 3, 8'h00, 2'b00);
        run_cmd("read 5 retry",     RD, 5, 8'h00, 2,  2'b01, 7, 8'h3C, 2'b00);
        run_cmd("write exhaust",    WR, 6, 8'h77, 99, 2'b10, 8, 8'h00, 2'b10);
        run_cmd("unlock unlocked",  UL, 0, 8'h00, 0,  2'b00, 1, 8'h00, 2'b01);
        run_cmd("lock retry",       LK, 0, 8'h00, 1,  2'b11, 4, 8'h00, 2'b00);
        run_cmd("lock locked",      LK, 0, 8'h00, 0,  2'b00, 1, 8'h00, 2'b00);
        run_cmd("write 2 locked",   WR, 2, 8'h5A, 0,  2'b00, 3, 8'h00, 2'b00);
        run_cmd("read 2 locked",    RD, 2, 8'h00, 0,  2'b00, 3, 8'h5A, 2'b00);
        run_cmd("unlock",           UL, 0, 8'h00, 0,  2'b00, 2, 8'h00, 2'b00);
        run_cmd("lock exhaust",     LK, 0, 8'h00, 99, 2'b11, 8, 8'h00, 2'b11);
        run_cmd("lock",             LK, 0, 8'h00, 0,  2'b00, 2, 8'h00, 2'b00);

        // Abandon a locked WRITE during its DATA cycle.
        build(WR, 1, 8'h99, 0, 2'b00);
        lat_obs = -1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.cmd_valid = tr[0].accept; bus.cmd_op = WR; bus.cmd_addr = 3'd1; bus.cmd_wdata = 8'h99;
            bus.csm_ack = tr[0].ack; bus.csm_err = tr[0].err; bus.csm_out_data = tr[0].odata;
            check($sformatf("pre-reset cycle %0d outputs", i), 32'(sample()), 32'(tr[0].exp));
            void'(tr.pop_front());
        end
        #1 reset_n = 1'b0;
        #1 check("async reset outputs", 32'(sample()), 32'(idle_obs()));
        bus.cmd_valid = 1'b0; bus.csm_ack = 1'b0;
        tr.delete();
        model_locked = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("post-reset idle %0d", i), 32'(sample()), 32'(idle_obs()));
        end
        run_cmd("unlock after reset", UL, 0, 8'h00, 0, 2'b00, 1, 8'h00, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/csm_requester.md
# csm_requester

Processor-side initiator for one port of the critical section manager. It accepts single read, write, lock and unlock commands from a processor core over a valid/ready command interface. It sequences them onto the CSM port signals (address/data bus, rw, enable, hold, release) and retries rejected accesses. It returns one response per command, with read data and a CSM error code. One instance sits between each processor and its CSM port.

## Interface
Parameters:
- DATABITS, 8: width of the CSM address/data bus and of read/write data.
- MEMSIZE, 8: number of CSM registers. MEMBITS = $clog2(MEMSIZE).
- MAX_RETRY, 3: retries after a rejected attempt, so at most MAX_RETRY+1 attempts per command.

Ports:
- Clocking: one clock; reset is asynchronous and active-low (clk, reset_n).
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE; a command is accepted on a cycle with cmd_valid & cmd_ready.
- cmd_op  in  2  command: 00 READ, 01 WRITE, 10 LOCK, 11 UNLOCK.
- cmd_addr  in  MEMBITS  register index.
- cmd_wdata  in  DATABITS  write data.
- rsp_valid  out  1  one-cycle response pulse; there is no backpressure.
- rsp_rdata  out  DATABITS  read data, valid with rsp_valid on a READ; 0 otherwise.
- rsp_err  out  2  00 NO_ERROR, 01 IN_USE, 10 DUAL_WRITE, 11 DUAL_HOLD.
- csm_in_AD  out  DATABITS  CSM address/data bus; address zero-extended.
- csm_rw  out  1  write strobe.
- csm_enable  out  1  access request.
- csm_hold  out  1  lock request, level signal.
- csm_release  out  1  unlock pulse.
- csm_out_data  in  DATABITS  CSM read data.
- csm_err  in  2  CSM error code.
- csm_ack  in  1  CSM acknowledge.

## Operation
- Outputs: all csm_* outputs are registered.
- Command latch: cmd_op, cmd_addr and cmd_wdata are latched on acceptance.
- Lock flag: an internal `locked` flag is set by a successful LOCK and cleared by UNLOCK. csm_hold equals `locked`, except during HOLD_REQ, where it is forced to 1.
- States:
  - IDLE: bus idle (AD=0, rw=enable=release=0). On acceptance:
    - READ or WRITE go to ADDR.
    - LOCK goes to HOLD_REQ if !locked, otherwise to RESP with NO_ERROR.
    - UNLOCK goes to REL if locked, otherwise to RESP with IN_USE.
  - ADDR: enable=1, AD=addr, rw=(op==WRITE). csm_ack and csm_err are sampled at the end of the cycle.
    - ack=1: go to DATA.
    - ack=0: go to RETRY if the retry count is below MAX_RETRY, otherwise to RESP with rsp_err = the sampled csm_err.
  - DATA: enable=0, rw=0.
    - WRITE drives AD=wdata.
    - READ drives AD=0 and captures csm_out_data at the end of the cycle.
    - Next state is RESP with NO_ERROR.
  - RETRY: bus idle for one cycle, increment the retry count, then return to ADDR or HOLD_REQ according to the op.
  - HOLD_REQ: hold=1, with ack and err sampled at the end of the cycle.
    - ack=1: set locked and go to RESP with NO_ERROR.
    - ack=0: hold drops next cycle, then retry or fail exactly as in ADDR.
  - REL: hold=0, release=1 for one cycle; csm_err and csm_ack are ignored. Clear locked, then go to RESP with NO_ERROR.
  - RESP: rsp_valid=1 for one cycle, then go to IDLE. Clear the retry count.
- Accesses while locked: READ and WRITE proceed with csm_hold still high.
- Response data: rsp_rdata holds the captured data for a successful READ and is 0 for every other response.

## Timing
- Reset state: state IDLE, locked=0, retry count 0. All outputs are 0 except cmd_ready=1. Every csm_* output is 0.
- Reset mid-operation: the command in progress is abandoned and produces no response. csm_hold drops immediately because reset is asynchronous.
- Reference point: a command accepted at edge T.
- Successful READ or WRITE:
  - ADDR occupies T..T+1 and DATA occupies T+1..T+2.
  - rsp_valid is high T+2..T+3.
  - Accept-to-response latency is 3 cycles.
- Each rejected attempt adds 2 cycles (RETRY + ADDR).
- A command that fails every attempt responds 2(MAX_RETRY+1) cycles after acceptance.
- LOCK and UNLOCK: 2 cycles when the first attempt succeeds.
- No-bus LOCK/UNLOCK responses (already locked, or not locked): 1 cycle.
- Back-to-back commands: cmd_ready is 0 from acceptance through RESP, so the next command is accepted no earlier than the cycle after rsp_valid.

## Test plan
- Write then read: WRITE addr 3, data 0xA5 with ack=1, then READ addr 3 while the model returns 0xA5. Required: write data on AD during DATA; response at +3 cycles with rsp_rdata=0xA5 and rsp_err=00.
- Retry recovery: READ with ack=0 and err=01 on the first two ADDR cycles, then ack=1. Required: three ADDR cycles separated by idle cycles, rsp_err=00, response at +7 cycles.
- Retry exhaustion: WRITE with ack=0 and err=10 forever. Required: exactly 4 ADDR cycles, rsp_err=10, rsp_rdata=0, response at +8 cycles.
- Lock cycle: LOCK with ack=1, then WRITE, then UNLOCK. Required: csm_hold stays high from HOLD_REQ through the WRITE; a single release pulse with hold=0; all three responses have err=00.
- Illegal commands: UNLOCK while unlocked, and LOCK while locked. Required: no csm_* activity; rsp_err 01 and 00 respectively, each 1 cycle after acceptance.
- Reset mid-transaction: reset_n low during DATA of a WRITE. Required: all outputs clear asynchronously, no rsp_valid, and cmd_ready=1 after release of reset.
